register_window_file: RTL and testbench

Parametrised SPARC-style windowed register file for the datapath, replacing the fixed four-window register block. It has two combinational read ports (PortA, PortB), one synchronous write port (PortC) and an owned current window pointer. Save/Restore move the pointer, with window overflow/underflow detection against an internal Window Invalid Mask. The control unit consumes the registered trap pulse.

---
 rtl/register_window_file.sv | 87 ++++++++
 tb/tb_register_window_file.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/register_window_file.sv
// register_window_file: SPARC-style windowed register file with two combinational read ports and one write port.
// Owns the current window pointer and window invalid mask, and raises a registered trap on refused Save/Restore.
module register_window_file #(
    parameter int WIDTH    = 32,
    parameter int NWINDOWS = 4,
    parameter int CWPW     = $clog2(NWINDOWS)
) (
    input  logic                Clk,
    input  logic                Clr,
    output logic [WIDTH-1:0]    PortA,
    output logic [WIDTH-1:0]    PortB,
    input  logic [WIDTH-1:0]    PortC,
    input  logic [4:0]          Sa,
    input  logic [4:0]          Sb,
    input  logic [4:0]          Load_Select,
    input  logic                RF_Load_Enable,
    input  logic                RF_Clear_Enable,
    input  logic [4:0]          Clear_Select,
    input  logic                Save,
    input  logic                Restore,
    input  logic                Cwp_Load,
    input  logic [CWPW-1:0]     Cwp_In,
    input  logic                Wim_Load,
    input  logic [NWINDOWS-1:0] Wim_In,
    output logic [CWPW-1:0]     Cwp,
    output logic [NWINDOWS-1:0] Wim,
    output logic                Trap,
    output logic                Trap_Type
);
    localparam int NREGS = 8 + 16 * NWINDOWS;
    localparam int AW = $clog2(NREGS);
    localparam logic [CWPW-1:0] CWP_ONE = CWPW'(1);

    logic [WIDTH-1:0] regs [NREGS];
    logic [CWPW-1:0]  cwp_dec, cwp_inc;
    logic             save_go, restore_go, save_trap, restore_trap;
    logic [AW-1:0]    load_addr, clear_addr;

    // Outs and locals of window w are contiguous; ins alias the outs of window w+1 (wraps since N is a power of two).
    function automatic logic [AW-1:0] phys(input logic [4:0] r, input logic [CWPW-1:0] w);
        logic [CWPW-1:0] wn;
        wn = w + CWP_ONE;
        return r < 5'd8  ? AW'(r) :
               r < 5'd24 ? AW'(16 * int'(w) + int'(r)) :
                           AW'(16 * int'(wn) + int'(r) - 16);
    endfunction

    always_comb begin
        cwp_dec      = Cwp - CWP_ONE;
        cwp_inc      = Cwp + CWP_ONE;
        save_go      = Save && !Restore && !Cwp_Load;
        restore_go   = Restore && !Save && !Cwp_Load;
        save_trap    = save_go && Wim[cwp_dec];
        restore_trap = restore_go && Wim[cwp_inc];
        load_addr    = phys(Load_Select, Cwp);
        clear_addr   = phys(Clear_Select, Cwp);
    end

    // Physical register 0 is never written, so r0 reads zero for free.
    assign PortA = regs[phys(Sa, Cwp)];
    assign PortB = regs[phys(Sb, Cwp)];

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (RF_Load_Enable && load_addr != '0) regs[load_addr] <= PortC;
            if (RF_Clear_Enable) regs[clear_addr] <= '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            Cwp       <= CWPW'(NWINDOWS - 1);
            Wim       <= '0;
            Trap      <= 1'b0;
            Trap_Type <= 1'b0;
        end else begin
            if (Cwp_Load) Cwp <= Cwp_In;
            else if (save_go && !save_trap) Cwp <= cwp_dec;
            else if (restore_go && !restore_trap) Cwp <= cwp_inc;
            if (Wim_Load) Wim <= Wim_In;
            Trap <= save_trap || restore_trap;
            if (save_trap || restore_trap) Trap_Type <= restore_trap;
        end
    end
endmodule

// File: tb/tb_register_window_file.sv
// tb_register_window_file: directed plus random stimulus against a window-level reference model.
// Expectations are queued by the driver and compared by a separate monitor on the falling edge.
module tb_register_window_file;
    localparam int N  = 4;
    localparam int CW = 2;

    logic          clk, clr;
    logic [31:0]   port_a, port_b, port_c;
    logic [4:0]    sa, sb, load_sel, clr_sel;
    logic          load_en, clr_en, save, restore, cwp_load, wim_load;
    logic [CW-1:0] cwp_in, cwp;
    logic [N-1:0]  wim_in, wim;
    logic          trap, trap_type;

    register_window_file #(.WIDTH(32), .NWINDOWS(N)) dut (
        .Clk(clk), .Clr(clr), .PortA(port_a), .PortB(port_b), .PortC(port_c),
        .Sa(sa), .Sb(sb), .Load_Select(load_sel), .RF_Load_Enable(load_en),
        .RF_Clear_Enable(clr_en), .Clear_Select(clr_sel), .Save(save), .Restore(restore),
        .Cwp_Load(cwp_load), .Cwp_In(cwp_in), .Wim_Load(wim_load), .Wim_In(wim_in),
        .Cwp(cwp), .Wim(wim), .Trap(trap), .Trap_Type(trap_type)
    );

    typedef struct {
        logic [31:0]   a, b;
        logic [CW-1:0] cwp;
        logic [N-1:0]  wim;
        logic          trap, ttype;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail = 0;

    // Reference model organised as globals plus per-window outs/locals.
    logic [31:0] g [8];
    logic [31:0] outs [N][8];
    logic [31:0] lcl [N][8];
    int          m_cwp;
    logic [N-1:0] m_wim;
    logic        m_trap, m_ttype;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mread(input int r);
        if (r == 0) return 32'h0;
        if (r < 8) return g[r];
        if (r < 16) return outs[m_cwp][r-8];
        if (r < 24) return lcl[m_cwp][r-16];
        return outs[(m_cwp + 1) % N][r-24];
    endfunction

    task automatic mwrite(input int r, input logic [31:0] v);
        if (r == 0) return;
        if (r < 8) g[r] = v;
        else if (r < 16) outs[m_cwp][r-8] = v;
        else if (r < 24) lcl[m_cwp][r-16] = v;
        else outs[(m_cwp + 1) % N][r-24] = v;
    endtask

    task automatic model_step();
        int t;
        logic tn;
        if (clr) begin
            for (int i = 0; i < 8; i++) g[i] = 32'h0;
            for (int w = 0; w < N; w++)
                for (int i = 0; i < 8; i++) begin
                    outs[w][i] = 32'h0;
                    lcl[w][i] = 32'h0;
                end
            m_cwp = N - 1;
            m_wim = '0;
            m_trap = 1'b0;
            m_ttype = 1'b0;
            return;
        end
        if (load_en) mwrite(int'(load_sel), port_c);
        if (clr_en) mwrite(int'(clr_sel), 32'h0);
        tn = 1'b0;
        if (cwp_load) m_cwp = int'(cwp_in);
        else if (save && !restore) begin
            t = (m_cwp + N - 1) % N;
            if (m_wim[t]) begin tn = 1'b1; m_ttype = 1'b0; end
            else m_cwp = t;
        end else if (restore && !save) begin
            t = (m_cwp + 1) % N;
            if (m_wim[t]) begin tn = 1'b1; m_ttype = 1'b1; end
            else m_cwp = t;
        end
        m_trap = tn;
        if (wim_load) m_wim = wim_in;
    endtask

    task automatic tick();
        exp_t e;
        e.a = mread(int'(sa));
        e.b = mread(int'(sb));
        e.cwp = CW'(m_cwp);
        e.wim = m_wim;
        e.trap = m_trap;
        e.ttype = m_ttype;
        q.push_back(e);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; load_en = 0; clr_en = 0; save = 0; restore = 0;
        cwp_load = 0; wim_load = 0; cwp_in = '0; wim_in = '0;
        load_sel = '0; clr_sel = '0; port_c = '0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("PortA", port_a, e.a);
            chk("PortB", port_b, e.b);
            chk("Cwp", 32'(cwp), 32'(e.cwp));
            chk("Wim", 32'(wim), 32'(e.wim));
            chk("Trap", 32'(trap), 32'(e.trap));
            chk("Trap_Type", 32'(trap_type), 32'(e.ttype));
        end
    end

    initial begin
        idle();
        sa = 0; sb = 0;
        clr = 1;
        model_step();
        @(posedge clk);
        #1;
        clr = 0;
        sa = 8; sb = 31; tick();
        for (int r = 8; r < 32; r++) begin
            load_en = 1; load_sel = 5'(r); port_c = 32'(r); tick();
        end
        load_sel = 0; port_c = 32'hFFFF_FFFF; tick();
        load_en = 0;
        for (int r = 0; r < 32; r++) begin
            sa = 5'(r); sb = 5'(31 - r); tick();
        end
        load_en = 1; load_sel = 8; port_c = 32'hA5; tick();
        load_en = 0;
        save = 1; tick();
        save = 0; sa = 24; tick();
        restore = 1; tick();
        restore = 0; sa = 8; tick();
        for (int r = 1; r < 8; r++) begin
            load_en = 1; load_sel = 5'(r); port_c = $urandom; tick();
        end
        load_en = 0;
        for (int i = 0; i < 4; i++) begin
            save = 1; sa = 5'(1 + i); sb = 5'(7 - i); tick();
        end
        save = 0; tick();
        save = 1; tick();
        save = 0; wim_load = 1; wim_in = 4'b0010; tick();
        wim_load = 0; save = 1; tick();
        save = 0; tick(); tick();
        cwp_load = 1; cwp_in = 0; tick();
        cwp_load = 0; restore = 1; tick();
        restore = 0; tick(); tick();
        wim_load = 1; wim_in = 0; tick();
        wim_load = 0;
        load_en = 1; clr_en = 1; load_sel = 12; clr_sel = 12; port_c = 32'hDEAD_BEEF; tick();
        load_en = 0; clr_en = 0; sa = 12; tick();
        save = 1; restore = 1; tick();
        save = 0; restore = 0; tick();
        cwp_load = 1; cwp_in = 1; save = 1; tick();
        idle(); tick();
        load_en = 1; load_sel = 16; port_c = 32'h1234; clr = 1; tick();
        idle(); sa = 16; tick();
        repeat (500) begin
            clr = ($urandom_range(0, 49) == 0);
            load_en = $urandom_range(0, 1) == 1;
            clr_en = $urandom_range(0, 4) == 0;
            save = $urandom_range(0, 2) == 0;
            restore = $urandom_range(0, 2) == 0;
            cwp_load = $urandom_range(0, 9) == 0;
            wim_load = $urandom_range(0, 9) == 0;
            cwp_in = CW'($urandom_range(0, N - 1));
            wim_in = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            sa = 5'($urandom); sb = 5'($urandom);
            load_sel = 5'($urandom); clr_sel = 5'($urandom);
            port_c = $urandom;
            tick();
        end
        idle(); tick();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
